pwm_peripheral: RTL



---
 rtl/pwm_peripheral_if.sv | 31 +++
 rtl/pwm_peripheral.sv | 60 ++++++
 2 files changed

// File: rtl/pwm_peripheral_if.sv
// Configuration and pin-drive bundle between the SPI register file, the PWM
// block and the output pads.
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is held low, driven static high, or follows a
// shared 256-step PWM waveform whose duty is latched only at period boundaries.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_peripheral_if.slave  bus
);

    localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [15:0] out_q, out_d;
    logic        period_start_q, period_start_d;

    logic        tick;
    logic        boundary;
    logic        pwm;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    always_comb begin
        tick           = (presc_q == PRESC_LAST);
        boundary       = tick && (step_q == 8'hFF);
        presc_d        = tick ? 16'd0 : presc_q + 16'd1;
        step_d         = tick ? step_q + 8'd1 : step_q;
        // Duty is only sampled on the last cycle of a period so a period never
        // mixes two duty values.
        shadow_d       = boundary ? bus.pwm_duty_cycle : shadow_q;
        period_start_d = boundary;
        pwm            = (shadow_q == 8'hFF) || (step_q < shadow_q);
        out_d          = en_out & (~en_pwm | {16{pwm}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            step_q         <= '0;
            shadow_q       <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            step_q         <= step_d;
            shadow_q       <= shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule
